regsel_seq: RTL and testbench

Parametrised, registered register-select unit for the CPU datapath. It decodes microsequencer and instruction-operand register selections into one-hot output-enable and load-enable vectors. Instruction operand fields are latched on an IR-load strobe. A block-transfer sequencer steps through a register mask, one register per step, to support multi-register push/pop and move microcode. It sits between the microsequencer/instruction register and the register file enables.

---
 rtl/regsel_seq.sv | 194 +++++++++++++++++++
 tb/tb_regsel_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regsel_seq.sv
// Register-select unit. It decodes microsequencer and instruction-operand selects into registered
// one-hot OE and load enables, and runs a mask-driven block-transfer sequencer for push/pop/move.
module regsel_seq #(
    parameter int NREGS = 8,
    parameter int SELW  = 3,
    parameter int NOPS  = 3,
    parameter int SRCW  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ir_load,
    input  logic [NOPS*SELW-1:0] ops_in,
    input  logic                 oe,
    input  logic                 load,
    input  logic [SRCW-1:0]      oe_src,
    input  logic [SRCW-1:0]      load_src,
    input  logic [SELW-1:0]      useq_oe_sel,
    input  logic [SELW-1:0]      useq_load_sel,
    input  logic                 blk_start,
    input  logic [NREGS-1:0]     blk_mask,
    input  logic                 blk_dir,
    input  logic                 blk_is_load,
    input  logic                 blk_step,
    output logic [NREGS-1:0]     reg_oes,
    output logic [NREGS-1:0]     reg_loads,
    output logic                 blk_busy,
    output logic                 blk_done,
    output logic [SELW-1:0]      blk_cur,
    output logic                 sel_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state_r, stateNext_s;
    logic [NOPS*SELW-1:0] opsReg_r;
    logic [NREGS-1:0]     wmask_r, wmaskNext_s, remMask_s, seqVec_s;
    logic                 dir_r, dirNext_s, isLoad_r, isLoadNext_s;
    logic [SELW-1:0]      cur_r, curNext_s;
    logic [NREGS-1:0]     oes_r, loads_r, oesNext_s, loadsNext_s;
    logic                 done_r, doneNext_s, err_r, errNext_s;
    logic                 seqOwnsOe_s, seqOwnsLoad_s;
    logic [NREGS:0]       oeDec_s, loadDec_s;

    function automatic logic [NREGS-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NREGS-1:0] vec;
        vec = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            vec[i] = (32'(idx) == i);
        end
        return vec;
    endfunction

    function automatic logic [SELW-1:0] lowIdx(input logic [NREGS-1:0] m);
        logic [SELW-1:0] idx;
        idx = {SELW{1'b0}};
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (m[i]) idx = SELW'(i);
        end
        return idx;
    endfunction

    function automatic logic [SELW-1:0] highIdx(input logic [NREGS-1:0] m);
        logic [SELW-1:0] idx;
        idx = {SELW{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            if (m[i]) idx = SELW'(i);
        end
        return idx;
    endfunction

    // Returns {error, one-hot enable}; source 0 is the microsequencer select, k is operand k-1.
    function automatic logic [NREGS:0] decodeSel(input logic en, input logic [SRCW-1:0] src,
                                                 input logic [SELW-1:0] useqSel,
                                                 input logic [NOPS*SELW-1:0] ops);
        logic [SELW-1:0] sel;
        logic            bad;
        sel = useqSel;
        bad = (32'(src) > NOPS);
        for (int k = 0; k < NOPS; k++) begin
            if (32'(src) == k + 1) sel = ops[k*SELW +: SELW];
        end
        bad = bad | (32'(sel) >= NREGS);
        if (!en) begin
            return {1'b0, {NREGS{1'b0}}};
        end else if (bad) begin
            return {1'b1, {NREGS{1'b0}}};
        end else begin
            return {1'b0, onehot(sel)};
        end
    endfunction

    // Block sequencer next state: mask capture, per-step emission and completion.
    always_comb begin
        stateNext_s  = state_r;
        wmaskNext_s  = wmask_r;
        dirNext_s    = dir_r;
        isLoadNext_s = isLoad_r;
        curNext_s    = cur_r;
        doneNext_s   = 1'b0;
        seqVec_s     = {NREGS{1'b0}};
        remMask_s    = wmask_r;
        case (state_r)
            IDLE: begin
                if (blk_start) begin
                    if (blk_mask != {NREGS{1'b0}}) begin
                        stateNext_s  = RUN;
                        wmaskNext_s  = blk_mask;
                        dirNext_s    = blk_dir;
                        isLoadNext_s = blk_is_load;
                        curNext_s    = blk_dir ? highIdx(blk_mask) : lowIdx(blk_mask);
                    end else begin
                        doneNext_s = 1'b1;
                    end
                end else begin
                    doneNext_s = 1'b0;
                end
            end
            RUN: begin
                if (blk_step) begin
                    seqVec_s    = onehot(cur_r);
                    remMask_s   = wmask_r & ~seqVec_s;
                    wmaskNext_s = remMask_s;
                    if (remMask_s == {NREGS{1'b0}}) begin
                        stateNext_s = IDLE;
                        doneNext_s  = 1'b1;
                        curNext_s   = {SELW{1'b0}};
                    end else begin
                        curNext_s = dir_r ? highIdx(remMask_s) : lowIdx(remMask_s);
                    end
                end else begin
                    seqVec_s = {NREGS{1'b0}};
                end
            end
            default: begin
                stateNext_s = IDLE;
                wmaskNext_s = {NREGS{1'b0}};
                curNext_s   = {SELW{1'b0}};
            end
        endcase
    end

    // Enable decode; the sequencer takes over whichever path it was started on.
    always_comb begin
        seqOwnsOe_s   = (state_r == RUN) && !isLoad_r;
        seqOwnsLoad_s = (state_r == RUN) && isLoad_r;
        oeDec_s       = decodeSel(oe && !seqOwnsOe_s, oe_src, useq_oe_sel, opsReg_r);
        loadDec_s     = decodeSel(load && !seqOwnsLoad_s, load_src, useq_load_sel, opsReg_r);
        oesNext_s     = seqOwnsOe_s ? seqVec_s : oeDec_s[NREGS-1:0];
        loadsNext_s   = seqOwnsLoad_s ? seqVec_s : loadDec_s[NREGS-1:0];
        errNext_s     = oeDec_s[NREGS] | loadDec_s[NREGS];
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            wmask_r  <= {NREGS{1'b0}};
            dir_r    <= 1'b0;
            isLoad_r <= 1'b0;
            cur_r    <= {SELW{1'b0}};
            done_r   <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            wmask_r  <= wmaskNext_s;
            dir_r    <= dirNext_s;
            isLoad_r <= isLoadNext_s;
            cur_r    <= curNext_s;
            done_r   <= doneNext_s;
        end
    end

    // Operand latch and registered enable outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opsReg_r <= {(NOPS*SELW){1'b0}};
            oes_r    <= {NREGS{1'b0}};
            loads_r  <= {NREGS{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (ir_load) opsReg_r <= ops_in;
            oes_r   <= oesNext_s;
            loads_r <= loadsNext_s;
            err_r   <= errNext_s;
        end
    end

    assign reg_oes   = oes_r;
    assign reg_loads = loads_r;
    assign blk_busy  = (state_r == RUN);
    assign blk_done  = done_r;
    assign blk_cur   = cur_r;
    assign sel_err   = err_r;

endmodule

// File: tb/tb_regsel_seq.sv
// Scoreboard bench for regsel_seq: directed scenarios plus random traffic, checked against a
// queue-based reference model of the select rules and the block-transfer visiting order.
module tb_regsel_seq;
    localparam int NREGS = 8;
    localparam int SELW  = 4;
    localparam int NOPS  = 3;
    localparam int SRCW  = 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 ir_load = 1'b0;
    logic [NOPS*SELW-1:0] ops_in = '0;
    logic                 oe = 1'b0, load = 1'b0;
    logic [SRCW-1:0]      oe_src = '0, load_src = '0;
    logic [SELW-1:0]      useq_oe_sel = '0, useq_load_sel = '0;
    logic                 blk_start = 1'b0;
    logic [NREGS-1:0]     blk_mask = '0;
    logic                 blk_dir = 1'b0, blk_is_load = 1'b0, blk_step = 1'b0;
    logic [NREGS-1:0]     reg_oes, reg_loads;
    logic                 blk_busy, blk_done, sel_err;
    logic [SELW-1:0]      blk_cur;

    always #5 clk = ~clk;

    regsel_seq #(.NREGS(NREGS), .SELW(SELW), .NOPS(NOPS), .SRCW(SRCW)) dut (
        .clk(clk), .reset_n(reset_n), .ir_load(ir_load), .ops_in(ops_in),
        .oe(oe), .load(load), .oe_src(oe_src), .load_src(load_src),
        .useq_oe_sel(useq_oe_sel), .useq_load_sel(useq_load_sel),
        .blk_start(blk_start), .blk_mask(blk_mask), .blk_dir(blk_dir),
        .blk_is_load(blk_is_load), .blk_step(blk_step),
        .reg_oes(reg_oes), .reg_loads(reg_loads), .blk_busy(blk_busy),
        .blk_done(blk_done), .blk_cur(blk_cur), .sel_err(sel_err)
    );

    typedef struct {
        bit irLoad; logic [11:0] ops; bit oe; bit load;
        int oeSrc; int loadSrc; int oeSel; int loadSel;
        bit start; logic [7:0] mask; bit dir; bit isLoad; bit step;
    } stim_t;

    typedef struct {
        logic [7:0] oes; logic [7:0] loads; logic busy; logic done; logic [3:0] cur; logic err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails = 0;

    // Reference model state: operand values, and the remaining visit order as a list.
    int   mOps[NOPS];
    bit   mBusy = 1'b0;
    bit   mIsLoad = 1'b0;
    int   mOrder[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.irLoad = 0; s.ops = 12'h000; s.oe = 0; s.load = 0;
        s.oeSrc = 0; s.loadSrc = 0; s.oeSel = 0; s.loadSel = 0;
        s.start = 0; s.mask = 8'h00; s.dir = 0; s.isLoad = 0; s.step = 0;
        return s;
    endfunction

    function automatic void modelDecode(input bit en, input int src, input int sel,
                                        output logic [7:0] vec, output bit err);
        int idx;
        vec = 8'h00;
        err = 1'b0;
        if (!en) return;
        if (src == 0) idx = sel;
        else if (src <= NOPS) idx = mOps[src-1];
        else begin
            err = 1'b1;
            return;
        end
        if (idx >= NREGS) begin
            err = 1'b1;
            return;
        end
        vec = 8'd1 << idx;
    endfunction

    task automatic cycle(input stim_t s);
        exp_t       e;
        logic [7:0] v;
        bit         er;
        int         idx;
        @(negedge clk);
        ir_load = s.irLoad; ops_in = s.ops; oe = s.oe; load = s.load;
        oe_src = 3'(s.oeSrc); load_src = 3'(s.loadSrc);
        useq_oe_sel = 4'(s.oeSel); useq_load_sel = 4'(s.loadSel);
        blk_start = s.start; blk_mask = s.mask; blk_dir = s.dir;
        blk_is_load = s.isLoad; blk_step = s.step;

        e.oes = 8'h00; e.loads = 8'h00; e.err = 1'b0; e.done = 1'b0;
        if (!(mBusy && !mIsLoad)) begin
            modelDecode(s.oe, s.oeSrc, s.oeSel, v, er);
            e.oes = v; e.err = e.err | er;
        end
        if (!(mBusy && mIsLoad)) begin
            modelDecode(s.load, s.loadSrc, s.loadSel, v, er);
            e.loads = v; e.err = e.err | er;
        end
        if (mBusy) begin
            if (s.step) begin
                idx = mOrder.pop_front();
                if (mIsLoad) e.loads = 8'd1 << idx;
                else e.oes = 8'd1 << idx;
                if (mOrder.size() == 0) begin
                    mBusy = 1'b0;
                    e.done = 1'b1;
                end
            end
        end else if (s.start) begin
            mOrder.delete();
            for (int i = 0; i < NREGS; i++) begin
                int r;
                r = s.dir ? (NREGS - 1 - i) : i;
                if (s.mask[r]) mOrder.push_back(r);
            end
            if (mOrder.size() == 0) e.done = 1'b1;
            else begin
                mBusy = 1'b1;
                mIsLoad = s.isLoad;
            end
        end
        e.busy = mBusy;
        e.cur  = mBusy ? 4'(mOrder[0]) : 4'd0;
        if (s.irLoad) begin
            for (int k = 0; k < NOPS; k++) mOps[k] = int'(s.ops[k*SELW +: SELW]);
        end
        expQ.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        ir_load = 0; oe = 0; load = 0; blk_start = 0; blk_step = 0;
        #1;
        chk("rst_reg_oes", 32'(reg_oes), 32'd0);
        chk("rst_reg_loads", 32'(reg_loads), 32'd0);
        chk("rst_blk_busy", 32'(blk_busy), 32'd0);
        chk("rst_blk_done", 32'(blk_done), 32'd0);
        chk("rst_blk_cur", 32'(blk_cur), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        expQ.delete();
        mOrder.delete();
        mBusy = 1'b0;
        mIsLoad = 1'b0;
        for (int k = 0; k < NOPS; k++) mOps[k] = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every cycle's registered outputs are compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("reg_oes", 32'(reg_oes), 32'(e.oes));
                chk("reg_loads", 32'(reg_loads), 32'(e.loads));
                chk("blk_busy", 32'(blk_busy), 32'(e.busy));
                chk("blk_done", 32'(blk_done), 32'(e.done));
                chk("blk_cur", 32'(blk_cur), 32'(e.cur));
                chk("sel_err", 32'(sel_err), 32'(e.err));
            end
        end
    end

    initial begin
        stim_t s;
        for (int k = 0; k < NOPS; k++) mOps[k] = 0;
        doReset();

        // Operand latch and source stepping.
        s = idleStim(); s.irLoad = 1; s.ops = {4'd7, 4'd3, 4'd1}; cycle(s);
        for (int src = 0; src <= NOPS; src++) begin
            s = idleStim(); s.oe = 1; s.oeSel = 2; s.oeSrc = src; cycle(s);
        end
        // Shared register on both paths, then drop, then same-cycle latch uses old operand.
        s = idleStim(); s.oe = 1; s.oeSrc = 1; s.load = 1; s.loadSrc = 1; cycle(s);
        s = idleStim(); cycle(s);
        s = idleStim(); s.oe = 1; s.oeSrc = 1; s.irLoad = 1; s.ops = {4'd7, 4'd3, 4'd5}; cycle(s);
        s = idleStim(); s.oe = 1; s.oeSrc = 1; cycle(s);

        // Ascending OE block with concurrent microsequencer load.
        s = idleStim(); s.start = 1; s.mask = 8'hA5; s.load = 1; s.loadSel = 6; cycle(s);
        repeat (5) begin
            s = idleStim(); s.step = 1; s.load = 1; s.loadSel = 6; s.oe = 1; s.oeSrc = 5; cycle(s);
        end
        // Descending load block with a stall, then an empty-mask start.
        s = idleStim(); s.start = 1; s.mask = 8'h12; s.dir = 1; s.isLoad = 1; cycle(s);
        s = idleStim(); s.step = 1; s.start = 1; s.mask = 8'hFF; cycle(s);
        s = idleStim(); cycle(s);
        s = idleStim(); s.step = 1; cycle(s);
        s = idleStim(); s.start = 1; s.mask = 8'h00; cycle(s);
        s = idleStim(); cycle(s);

        // Select errors: bad source, out-of-range index, bad load source.
        s = idleStim(); s.oe = 1; s.oeSrc = 5; cycle(s);
        s = idleStim(); s.oe = 1; s.oeSel = 9; cycle(s);
        s = idleStim(); s.load = 1; s.loadSrc = 4; s.oe = 1; s.oeSel = 3; cycle(s);

        // Reset in the middle of a four-register block, then a fresh block.
        s = idleStim(); s.start = 1; s.mask = 8'h3C; cycle(s);
        s = idleStim(); s.step = 1; cycle(s);
        s = idleStim(); s.step = 1; cycle(s);
        doReset();
        s = idleStim(); s.start = 1; s.mask = 8'h81; s.dir = 1; cycle(s);
        repeat (3) begin
            s = idleStim(); s.step = 1; cycle(s);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) doReset();
            s.irLoad  = ($urandom_range(0, 4) == 0);
            s.ops     = 12'($urandom);
            s.oe      = 1'($urandom_range(0, 1));
            s.load    = 1'($urandom_range(0, 1));
            s.oeSrc   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            s.loadSrc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            s.oeSel   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            s.loadSel = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            s.start   = ($urandom_range(0, 5) == 0);
            s.mask    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            s.dir     = 1'($urandom_range(0, 1));
            s.isLoad  = 1'($urandom_range(0, 1));
            s.step    = ($urandom_range(0, 3) != 0);
            cycle(s);
        end
        s = idleStim(); cycle(s);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
